// File: rtl/capture_ctrl.sv
// Purpose: sequences one I/Q capture: fill a sample buffer, wait for the last
//          write response, then read every slot back out to a valid/ready stream.
// Latency: one cycle from in_valid to the registered write strobe; each readout
//          slot takes RD_REQ + buffer read latency + OUT_HOLD + RD_ACK cycles.
// Backpressure: OUT_HOLD keeps out_valid/out_i/out_q frozen while out_ready=0,
//          and the read slot is only released (rd_ready) after the transfer.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          arm a capture (IDLE only) / return to IDLE from anywhere
//   in_valid, in_i, in_q  incoming sample stream, sampled only in FILL
//   wr_addr/valid/data    buffer write port, data packed {I,Q}
//   wr_ack                buffer write response, one cycle after the write
//   rd_addr/valid/ready   buffer read request and read-slot release
//   rd_data_valid/i/q     buffer read response
//   out_valid/i/q, out_ready  downstream stream
//   busy, done            not-IDLE status / end-of-readout pulse
module capture_ctrl #(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_valid,
  input  logic signed [i_bits-1:0]   in_i,
  input  logic signed [q_bits-1:0]   in_q,
  output logic [index_bits-1:0]      wr_addr,
  output logic                       wr_valid,
  output logic [i_bits+q_bits-1:0]   wr_data,
  input  logic                       wr_ack,
  output logic [index_bits-1:0]      rd_addr,
  output logic                       rd_valid,
  output logic                       rd_ready,
  input  logic                       rd_data_valid,
  input  logic signed [i_bits-1:0]   rd_i,
  input  logic signed [q_bits-1:0]   rd_q,
  output logic                       out_valid,
  output logic signed [i_bits-1:0]   out_i,
  output logic signed [q_bits-1:0]   out_q,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    FLUSH    = 3'd2,
    RD_REQ   = 3'd3,
    RD_WAIT  = 3'd4,
    OUT_HOLD = 3'd5,
    RD_ACK   = 3'd6
  } state_t;

  localparam logic [index_bits-1:0] LAST_IDX = index_bits'(buffer_length - 1);

  state_t                      state_q;
  logic [index_bits-1:0]       wr_cnt_q;
  logic [index_bits-1:0]       rd_cnt_q;
  logic [index_bits-1:0]       wr_cnt_d;
  logic [index_bits-1:0]       rd_cnt_d;

  logic                        wr_valid_q;
  logic [index_bits-1:0]       wr_addr_q;
  logic [i_bits+q_bits-1:0]    wr_data_q;
  logic                        rd_valid_q;
  logic [index_bits-1:0]       rd_addr_q;
  logic                        rd_ready_q;
  logic                        out_valid_q;
  logic signed [i_bits-1:0]    out_i_q;
  logic signed [q_bits-1:0]    out_q_q;
  logic                        done_q;

  // Counters only ever advance while below LAST_IDX, so these never wrap.
  assign wr_cnt_d = wr_cnt_q + index_bits'(1);
  assign rd_cnt_d = rd_cnt_q + index_bits'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Abort wins over every transition, including a start in IDLE.
        state_q     <= IDLE;
        wr_cnt_q    <= '0;
        rd_cnt_q    <= '0;
        wr_valid_q  <= 1'b0;
        wr_addr_q   <= '0;
        wr_data_q   <= '0;
        rd_valid_q  <= 1'b0;
        rd_addr_q   <= '0;
        rd_ready_q  <= 1'b0;
        out_valid_q <= 1'b0;
        out_i_q     <= '0;
        out_q_q     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              wr_cnt_q <= '0;
              rd_cnt_q <= '0;
              state_q  <= FILL;
            end
          end

          FILL: begin
            wr_valid_q <= in_valid;
            if (in_valid) begin
              wr_addr_q <= wr_cnt_q;
              wr_data_q <= {in_i, in_q};
              if (wr_cnt_q == LAST_IDX) begin
                state_q <= FLUSH;
              end else begin
                wr_cnt_q <= wr_cnt_d;
              end
            end
          end

          FLUSH: begin
            wr_valid_q <= 1'b0;
            // While the final write is still on the bus, any wr_ack belongs
            // to the previous write; only an ack seen afterwards is the last.
            if (wr_ack && !wr_valid_q) begin
              rd_valid_q <= 1'b1;
              rd_addr_q  <= rd_cnt_q;
              state_q    <= RD_REQ;
            end
          end

          RD_REQ: begin
            rd_valid_q <= 1'b0;
            state_q    <= RD_WAIT;
          end

          RD_WAIT: begin
            if (rd_data_valid) begin
              out_i_q     <= rd_i;
              out_q_q     <= rd_q;
              out_valid_q <= 1'b1;
              state_q     <= OUT_HOLD;
            end
          end

          OUT_HOLD: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              rd_ready_q  <= 1'b1;
              state_q     <= RD_ACK;
            end
          end

          RD_ACK: begin
            rd_ready_q <= 1'b0;
            if (rd_cnt_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              // Request the next slot straight away so rd_addr is already
              // valid during the RD_REQ cycle.
              rd_cnt_q   <= rd_cnt_d;
              rd_valid_q <= 1'b1;
              rd_addr_q  <= rd_cnt_d;
              state_q    <= RD_REQ;
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_addr   = rd_addr_q;
  assign rd_ready  = rd_ready_q;
  assign out_valid = out_valid_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

  // Write and read phases are disjoint, so the buffer never sees both strobes.
  a_no_wr_rd_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_valid_q && rd_valid_q));

  a_wr_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    wr_cnt_q <= LAST_IDX);

  a_rd_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    rd_cnt_q <= LAST_IDX);

endmodule

// File: tb/tb_capture_ctrl.sv
// Purpose: directed bench for capture_ctrl with a behavioural sample buffer.
// Latency: buffer acks writes after one cycle and returns read data two cycles
//          after rd_valid.
// Backpressure: out_ready is driven per scenario to stall the output stream.
module tb_capture_ctrl;

  localparam int LEN = 10;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic               in_valid;
  logic signed [11:0] in_i;
  logic signed [11:0] in_q;
  logic [3:0]         wr_addr;
  logic               wr_valid;
  logic [23:0]        wr_data;
  logic               wr_ack;
  logic [3:0]         rd_addr;
  logic               rd_valid;
  logic               rd_ready;
  logic               rd_data_valid;
  logic signed [11:0] rd_i;
  logic signed [11:0] rd_q;
  logic               out_valid;
  logic signed [11:0] out_i;
  logic signed [11:0] out_q;
  logic               out_ready;
  logic               busy;
  logic               done;

  int total = 0;
  int bad   = 0;

  logic signed [11:0] si [0:9];
  logic signed [11:0] sq [0:9];
  logic signed [11:0] got_i [0:15];
  logic signed [11:0] got_q [0:15];
  int got_n;
  int done_n;
  int rr_n;

  always #5 clk = ~clk;

  capture_ctrl #(
    .buffer_length(10),
    .index_bits   (4),
    .i_bits       (12),
    .q_bits       (12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_i         (in_i),
    .in_q         (in_q),
    .wr_addr      (wr_addr),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data_valid(rd_data_valid),
    .rd_i         (rd_i),
    .rd_q         (rd_q),
    .out_valid    (out_valid),
    .out_i        (out_i),
    .out_q        (out_q),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done)
  );

  // Behavioural buffer: one-cycle write ack, two-cycle read latency.
  logic [23:0] mem [0:15];
  logic        rd_s1;
  logic [3:0]  rd_a1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack        <= 1'b0;
      rd_s1         <= 1'b0;
      rd_a1         <= '0;
      rd_data_valid <= 1'b0;
      rd_i          <= '0;
      rd_q          <= '0;
    end else begin
      wr_ack <= wr_valid;
      if (wr_valid) mem[wr_addr] <= wr_data;
      rd_s1         <= rd_valid;
      rd_a1         <= rd_addr;
      rd_data_valid <= rd_s1;
      if (rd_s1) begin
        rd_i <= mem[rd_a1][23:12];
        rd_q <= mem[rd_a1][11:0];
      end
    end
  end

  // Every cycle: no simultaneous write/read strobe, no out-of-range address.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if ((wr_valid && rd_valid) || wr_addr >= 4'(LEN) || rd_addr >= 4'(LEN)) begin
        bad++;
        $display("FAIL strobe_addr_guard: wr_valid=%b rd_valid=%b wr_addr=%0d rd_addr=%0d, need no overlap and addr<%0d",
                 wr_valid, rd_valid, wr_addr, rd_addr, LEN);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill_all();
    for (int n = 0; n < LEN; n++) begin
      in_valid = 1'b1;
      in_i     = si[n];
      in_q     = sq[n];
      tick();
    end
    in_valid = 1'b0;
    in_i     = '0;
    in_q     = '0;
  endtask

  // Collect the output stream until done (plus a few trailing cycles).
  task automatic drain(input int budget);
    int extra;
    extra     = -1;
    out_ready = 1'b1;
    got_n     = 0;
    done_n    = 0;
    rr_n      = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (out_valid) begin
        if (got_n < 16) begin
          got_i[got_n] = out_i;
          got_q[got_n] = out_q;
        end
        got_n++;
      end
      if (rd_ready) rr_n++;
      if (extra > 0) begin
        extra--;
        if (extra == 0) break;
      end
      if (done) begin
        done_n++;
        if (extra < 0) extra = 4;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({wr_valid, rd_valid, rd_ready, out_valid, done, busy, wr_addr, rd_addr, wr_data, out_i, out_q} !== 62'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, need all zero",
               {wr_valid, rd_valid, rd_ready, out_valid, done, busy, wr_addr, rd_addr, wr_data, out_i, out_q});
    end
    @(negedge clk);
    rst_n = 1'b1;
    // in_valid outside FILL must not produce writes.
    in_valid = 1'b1;
    in_i     = 12'sd55;
    in_q     = -12'sd55;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (wr_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_ignores_in_valid: wr_valid=%b busy=%b, need 0 0", wr_valid, busy);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    for (int n = 0; n < LEN; n++) begin
      si[n] = 12'(n);
      sq[n] = 12'(-n);
    end
    pulse_start();
    total++;
    if (busy !== 1'b1 || wr_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_enter_fill: busy=%b wr_valid=%b, need 1 0", busy, wr_valid);
    end
    for (int n = 0; n < LEN; n++) begin
      logic [3:0] ea;
      ea       = 4'(n);
      in_valid = 1'b1;
      in_i     = si[n];
      in_q     = sq[n];
      tick();
      total++;
      if (wr_valid !== 1'b1 || wr_addr !== ea || wr_data !== {si[n], sq[n]}) begin
        bad++;
        $display("FAIL basic_write_%0d: valid=%b addr=%0d data=%h, need 1 %0d %h",
                 n, wr_valid, wr_addr, wr_data, ea, {si[n], sq[n]});
      end
    end
    in_valid = 1'b0;
    drain(300);
    total++;
    if (got_n !== LEN || done_n !== 1 || rr_n !== LEN || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_readout_counts: samples=%0d done=%0d rd_ready=%0d busy=%b, need 10 1 10 0",
               got_n, done_n, rr_n, busy);
    end
    for (int k = 0; k < LEN && k < got_n; k++) begin
      total++;
      if (got_i[k] !== si[k] || got_q[k] !== sq[k]) begin
        bad++;
        $display("FAIL basic_out_%0d: got i=%0d q=%0d, need i=%0d q=%0d", k, got_i[k], got_q[k], si[k], sq[k]);
      end
    end
  endtask

  task automatic test_toggle();
    int expn;
    for (int n = 0; n < LEN; n++) begin
      si[n] = 12'(100 + n);
      sq[n] = 12'(7 * n - 30);
    end
    expn = 0;
    pulse_start();
    for (int c = 0; c < 2 * LEN; c++) begin
      in_valid = (c % 2 == 0);
      if (in_valid) begin
        in_i = si[expn];
        in_q = sq[expn];
      end
      tick();
      total++;
      if (in_valid) begin
        if (wr_valid !== 1'b1 || wr_addr !== 4'(expn) || wr_data !== {si[expn], sq[expn]}) begin
          bad++;
          $display("FAIL toggle_write_%0d: valid=%b addr=%0d data=%h, need 1 %0d %h",
                   c, wr_valid, wr_addr, wr_data, expn, {si[expn], sq[expn]});
        end
        expn++;
      end else if (wr_valid !== 1'b0) begin
        bad++;
        $display("FAIL toggle_idle_%0d: wr_valid=%b, need 0", c, wr_valid);
      end
    end
    in_valid = 1'b0;
    drain(300);
    total++;
    if (got_n !== LEN || done_n !== 1) begin
      bad++;
      $display("FAIL toggle_counts: samples=%0d done=%0d, need 10 1", got_n, done_n);
    end
    for (int k = 0; k < LEN && k < got_n; k++) begin
      total++;
      if (got_i[k] !== si[k] || got_q[k] !== sq[k]) begin
        bad++;
        $display("FAIL toggle_out_%0d: got i=%0d q=%0d, need i=%0d q=%0d", k, got_i[k], got_q[k], si[k], sq[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int  seen;
    bit  found;
    for (int n = 0; n < LEN; n++) begin
      si[n] = 12'(-50 * n);
      sq[n] = 12'(3 * n + 1);
    end
    pulse_start();
    fill_all();
    out_ready = 1'b1;
    seen      = 0;
    found     = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (out_valid) begin
        if (seen == 3) begin
          found = 1'b1;
          break;
        end
        seen++;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL bp_reach_sample3: timed out after %0d samples, need sample 3", seen);
    end
    out_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_i !== si[3] || out_q !== sq[3] || rd_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: valid=%b i=%0d q=%0d rd_ready=%b, need 1 %0d %0d 0",
                 h, out_valid, out_i, out_q, rd_ready, si[3], sq[3]);
      end
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || rd_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b rd_ready=%b, need 0 1", out_valid, rd_ready);
    end
    tick();
    total++;
    if (rd_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_rd_ready_pulse: rd_ready=%b, need 0", rd_ready);
    end
    drain(300);
    total++;
    if (got_n !== 6 || done_n !== 1) begin
      bad++;
      $display("FAIL bp_tail_counts: samples=%0d done=%0d, need 6 1", got_n, done_n);
    end
    for (int k = 0; k < 6 && k < got_n; k++) begin
      total++;
      if (got_i[k] !== si[k + 4] || got_q[k] !== sq[k + 4]) begin
        bad++;
        $display("FAIL bp_out_%0d: got i=%0d q=%0d, need i=%0d q=%0d",
                 k + 4, got_i[k], got_q[k], si[k + 4], sq[k + 4]);
      end
    end
  endtask

  task automatic test_abort();
    bit found;
    int dn;
    for (int n = 0; n < LEN; n++) begin
      si[n] = 12'(11 * n - 40);
      sq[n] = 12'(200 - 9 * n);
    end
    pulse_start();
    fill_all();
    out_ready = 1'b1;
    found     = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (rd_valid && rd_addr === 4'd4) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL abort_reach_rd4: timed out, need rd_valid with rd_addr=4");
    end
    tick();
    total++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_in_rd_wait: busy=%b rd_valid=%b out_valid=%b, need 1 0 0", busy, rd_valid, out_valid);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({busy, done, wr_valid, rd_valid, rd_ready, out_valid, wr_addr, rd_addr, out_i, out_q} !== 38'd0) begin
      bad++;
      $display("FAIL abort_to_idle: got %h, need all zero",
               {busy, done, wr_valid, rd_valid, rd_ready, out_valid, wr_addr, rd_addr, out_i, out_q});
    end
    dn = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done || busy) dn++;
    end
    total++;
    if (dn !== 0) begin
      bad++;
      $display("FAIL abort_quiet: %0d cycles with done/busy, need 0", dn);
    end
    for (int n = 0; n < LEN; n++) begin
      si[n] = 12'(5 * n + 3);
      sq[n] = 12'(-7 * n);
    end
    pulse_start();
    fill_all();
    drain(300);
    total++;
    if (got_n !== LEN || done_n !== 1) begin
      bad++;
      $display("FAIL abort_rerun_counts: samples=%0d done=%0d, need 10 1", got_n, done_n);
    end
    for (int k = 0; k < LEN && k < got_n; k++) begin
      total++;
      if (got_i[k] !== si[k] || got_q[k] !== sq[k]) begin
        bad++;
        $display("FAIL abort_rerun_out_%0d: got i=%0d q=%0d, need i=%0d q=%0d", k, got_i[k], got_q[k], si[k], sq[k]);
      end
    end
  endtask

  task automatic test_abort_start();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_start_same_cycle: busy=%b, need 0", busy);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || wr_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_start_stays_idle: busy=%b wr_valid=%b, need 0 0", busy, wr_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < LEN; n++) begin
      si[n] = 12'(300 - 13 * n);
      sq[n] = 12'(17 * n - 90);
    end
    pulse_start();
    for (int n = 0; n < 6; n++) begin
      in_valid = 1'b1;
      in_i     = si[n];
      in_q     = sq[n];
      start    = (n == 3);  // start while busy must be ignored
      tick();
      start = 1'b0;
      total++;
      if (wr_valid !== 1'b1 || wr_addr !== 4'(n)) begin
        bad++;
        $display("FAIL midreset_write_%0d: valid=%b addr=%0d, need 1 %0d", n, wr_valid, wr_addr, n);
      end
    end
    in_i = si[6];
    in_q = sq[6];
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({wr_valid, rd_valid, rd_ready, out_valid, done, busy, wr_addr, rd_addr, wr_data, out_i, out_q} !== 62'd0) begin
      bad++;
      $display("FAIL midreset_async_clear: got %h, need all zero",
               {wr_valid, rd_valid, rd_ready, out_valid, done, busy, wr_addr, rd_addr, wr_data, out_i, out_q});
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (busy !== 1'b0 || wr_valid !== 1'b0) begin
        bad++;
        $display("FAIL midreset_waits_start_%0d: busy=%b wr_valid=%b, need 0 0", c, busy, wr_valid);
      end
    end
    in_valid = 1'b0;
    pulse_start();
    fill_all();
    drain(300);
    total++;
    if (got_n !== LEN || done_n !== 1) begin
      bad++;
      $display("FAIL midreset_rerun_counts: samples=%0d done=%0d, need 10 1", got_n, done_n);
    end
    for (int k = 0; k < LEN && k < got_n; k++) begin
      total++;
      if (got_i[k] !== si[k] || got_q[k] !== sq[k]) begin
        bad++;
        $display("FAIL midreset_rerun_out_%0d: got i=%0d q=%0d, need i=%0d q=%0d", k, got_i[k], got_q[k], si[k], sq[k]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_i      = '0;
    in_q      = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_toggle();
    test_backpressure();
    test_abort();
    test_abort_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter buffer_length, default 10, number of I/Q sample slots sequenced per capture.
REQ-002 Parameter index_bits, default 4, width of buffer addresses.
REQ-003 Parameter i_bits, default 12, signed I sample width.
REQ-004 Parameter q_bits, default 12, signed Q sample width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse that arms a capture; honoured only in IDLE.
REQ-008 abort  in  1  returns the block to IDLE from any state.
REQ-009 in_valid  in  1  input sample strobe; in_i  in  i_bits signed; in_q  in  q_bits signed.
REQ-010 wr_addr  out  index_bits; wr_valid  out  1; wr_data  out  i_bits+q_bits, packed {I,Q} with I in the MSBs.
REQ-011 wr_ack  in  1  buffer write-response valid, one cycle after the accepted write.
REQ-012 rd_addr  out  index_bits; rd_valid  out  1; rd_ready  out  1, read-valid clear to the buffer.
REQ-013 rd_data_valid  in  1; rd_i  in  i_bits signed; rd_q  in  q_bits signed; all from the buffer.
REQ-014 out_valid  out  1; out_i  out  i_bits signed; out_q  out  q_bits signed; out_ready  in  1; downstream stream.
REQ-015 busy  out  1, high in every state except IDLE; done  out  1, one-cycle pulse at the end of readout.

Function
REQ-016 The FSM SHALL have the states IDLE, FILL, FLUSH, RD_REQ, RD_WAIT, OUT_HOLD, RD_ACK.
REQ-017 IDLE: start=1 SHALL load wr_cnt=0, clear rd_cnt=0 and enter FILL next cycle.
REQ-018 FILL: each cycle with in_valid=1 SHALL register wr_valid=1, wr_addr=wr_cnt and wr_data={in_i,in_q}, then increment wr_cnt.
REQ-019 FILL: cycles with in_valid=0 SHALL register wr_valid=0 and leave wr_cnt unchanged.
REQ-020 The write accepted with wr_cnt=buffer_length-1 SHALL move the FSM to FLUSH; no further writes are issued.
REQ-021 FLUSH SHALL wait for wr_ack, then go to RD_REQ.
REQ-022 RD_REQ SHALL assert rd_valid=1 with rd_addr=rd_cnt for exactly one cycle, then go to RD_WAIT.
REQ-023 RD_WAIT SHALL wait for rd_data_valid=1, capture rd_i/rd_q into out_i/out_q, set out_valid=1 and go to OUT_HOLD.
REQ-024 OUT_HOLD SHALL hold out_valid, out_i and out_q stable until out_ready=1; a transfer is out_valid & out_ready.
REQ-025 On a transfer, out_valid SHALL drop next cycle and the FSM SHALL enter RD_ACK, which asserts rd_ready=1 for one cycle.
REQ-026 RD_ACK SHALL increment rd_cnt and return to RD_REQ.
REQ-027 When rd_cnt=buffer_length-1, RD_ACK SHALL instead pulse done=1 and go to IDLE.
REQ-028 wr_valid and rd_valid SHALL never be high in the same cycle, so the buffer's write/read address collision path is never exercised.
REQ-029 wr_cnt and rd_cnt SHALL be index_bits wide and never exceed buffer_length-1; there is no wrap-around.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 abort=1 SHALL take priority over every transition and, on the next edge, force IDLE with all strobes and counters at their reset values.
REQ-032 abort and start in the same IDLE cycle SHALL leave the FSM in IDLE.
REQ-033 in_valid SHALL be ignored outside FILL.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE and the following values: wr_cnt=0, rd_cnt=0.
REQ-035 The same reset SHALL force these outputs to 0: wr_valid, rd_valid, rd_ready, out_valid, done, busy, wr_addr, rd_addr, wr_data, out_i, out_q.
REQ-036 Reset asserted mid-capture SHALL discard the capture; after release the block waits for a new start.

Verification
REQ-037 Default parameters; start, then 10 consecutive in_valid samples I=n, Q=-n -> wr_addr 0..9 each with matching wr_data; FLUSH; readout returns out_i 0..9 and out_q 0..-9 in order; done pulses once.
REQ-038 in_valid toggled 1,0,1,0 during FILL -> exactly one write per valid cycle; addresses are contiguous with no gaps or duplicates.
REQ-039 out_ready held 0 for 5 cycles at sample 3 -> out_valid and data stay stable; rd_ready stays 0 until the transfer, then pulses once.
REQ-040 abort asserted in RD_WAIT at rd_cnt=4 -> IDLE next cycle, busy=0, no done pulse; a new start runs a full capture correctly.
REQ-041 rst_n pulsed low mid-FILL at wr_cnt=6 -> all outputs 0 asynchronously; a start pulse issued while busy=1 is ignored.
REQ-042 Every cycle of all scenarios -> assertion that wr_valid & rd_valid is never 1 and no address is ever >= buffer_length.
